// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: accepts one aligned access, runs a single-beat bus
// handshake with ack timeout, and returns the extended load data for one cycle.

module mau_lane #(
   parameter int IDX = 0
) (
   input  logic        is_word,
   input  logic        is_half,
   input  logic [1:0]  alo,
   input  logic [31:0] wdata,
   output logic        be,
   output logic [7:0]  wbyte
);
   localparam logic [1:0] LANE = 2'(IDX);

   // Sub-word stores replicate the low bytes so every enabled lane sees the right data.
   always_comb begin
      be    = 1'b0;
      wbyte = wdata[7:0];
      if (is_word) begin
         be    = 1'b1;
         wbyte = wdata[8*IDX +: 8];
      end else if (is_half) begin
         be    = (alo[1] == LANE[1]);
         wbyte = LANE[0] ? wdata[15:8] : wdata[7:0];
      end else begin
         be    = (alo == LANE);
         wbyte = wdata[7:0];
      end
   end
endmodule

module mem_access_unit #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        memwrite,
   input  logic        memtoreg,
   input  logic [2:0]  mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        adel,
   output logic        ades,
   output logic [31:0] bad_addr,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} size_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  op;
      logic        we;
   } req_t;

   state_t            state;
   req_t              req_q;
   logic [CW-1:0]     cnt;
   logic [31:0]       bad_addr_q;

   size_t             sz;
   logic              is_mem, aligned, idle_ok, accept, misal;
   logic [3:0]        lane_be;
   logic [3:0][7:0]   lane_wd;
   logic [31:0]       load_val;

   function automatic size_t dec_size(input logic [2:0] op);
      case (op)
         3'b110, 3'b111, 3'b010: dec_size = SZ_B;
         3'b100, 3'b101, 3'b001: dec_size = SZ_H;
         default:                dec_size = SZ_W;
      endcase
   endfunction

   // Extraction works off the latched op/addr, not the live MEM-stage inputs.
   function automatic logic [31:0] extract(input req_t r, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (r.addr[1:0])
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = r.addr[1] ? d[31:16] : d[15:0];
      case (r.op)
         3'b110:  extract = {{24{b[7]}}, b};
         3'b111:  extract = {24'h0, b};
         3'b100:  extract = {{16{h[15]}}, h};
         3'b101:  extract = {16'h0, h};
         default: extract = d;
      endcase
   endfunction

   assign sz      = dec_size(mem_op);
   assign is_mem  = req_valid & (memwrite | memtoreg);
   assign aligned = (sz == SZ_B) | ((sz == SZ_H) & ~addr[0]) | ((sz == SZ_W) & (addr[1:0] == 2'b00));
   assign idle_ok = ~rst & (state == S_IDLE) & is_mem;
   assign accept  = idle_ok & aligned;
   assign misal   = idle_ok & ~aligned;

   assign adel     = misal & ~memwrite;
   assign ades     = misal & memwrite;
   assign bad_addr = misal ? addr : bad_addr_q;
   assign stall    = ~rst & (accept | (state == S_REQ));
   assign bus_addr = bus_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
   assign load_val = extract(req_q, bus_rdata);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      mau_lane #(.IDX(i)) u_lane (
         .is_word (sz == SZ_W),
         .is_half (sz == SZ_H),
         .alo     (addr[1:0]),
         .wdata   (wdata),
         .be      (lane_be[i]),
         .wbyte   (lane_wd[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         req_q       <= '0;
         cnt         <= '0;
         bad_addr_q  <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_be      <= 4'h0;
         bus_wdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (misal) bad_addr_q <= addr;
               if (accept) begin
                  state     <= S_REQ;
                  cnt       <= '0;
                  req_q     <= '{addr: addr, op: mem_op, we: memwrite};
                  bus_req   <= 1'b1;
                  bus_we    <= memwrite;
                  bus_be    <= memwrite ? lane_be : 4'hF;
                  bus_wdata <= memwrite ? lane_wd : 32'h0;
               end
            end
            S_REQ: begin
               // Ack on the limit cycle still completes normally.
               if (bus_ack || cnt == CNT_LAST) begin
                  state       <= S_DONE;
                  bus_req     <= 1'b0;
                  bus_we      <= 1'b0;
                  bus_be      <= 4'h0;
                  bus_wdata   <= '0;
                  rdata_valid <= bus_ack & ~req_q.we;
                  bus_err     <= ~bus_ack;
                  if (!bus_ack)        rdata <= '0;
                  else if (!req_q.we)  rdata <= load_val;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               state       <= S_IDLE;
               rdata_valid <= 1'b0;
               bus_err     <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.

module tb_mem_access_unit;
   localparam int TO = 5;

   logic        clk = 1'b0;
   logic        rst, req_valid, memwrite, memtoreg, bus_ack;
   logic [2:0]  mem_op;
   logic [31:0] addr, wdata, bus_rdata;
   logic        stall, rdata_valid, adel, ades, bus_err, bus_req, bus_we;
   logic [31:0] rdata, bad_addr, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rd = 32'h0;

   always #5 clk = ~clk;

   mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .memwrite(memwrite), .memtoreg(memtoreg),
      .mem_op(mem_op), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
      .rdata_valid(rdata_valid), .adel(adel), .ades(ades), .bad_addr(bad_addr), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   function automatic int op_size(input logic [2:0] op);
      if (op == 3'b110 || op == 3'b111 || op == 3'b010) return 1;
      if (op == 3'b100 || op == 3'b101 || op == 3'b001) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
      int s = op_size(op);
      if (s == 1) return 4'(1 << (a % 4));
      if (s == 2) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] op, input logic [31:0] wd);
      int s = op_size(op);
      logic [31:0] b = wd & 32'hFF;
      logic [31:0] h = wd & 32'hFFFF;
      if (s == 1) return b * 32'h0101_0101;
      if (s == 2) return h * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      int s = op_size(op);
      logic [31:0] v = d;
      if (s == 1) begin
         v = (d >> (8 * (a % 4))) & 32'hFF;
         if (op == 3'b110 && v >= 128) v = v | 32'hFFFF_FF00;
      end else if (s == 2) begin
         v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (op == 3'b100 && v >= 32768) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // One complete access; ack_after is the REQ-cycle index of bus_ack (>= TO means never).
   task automatic run_txn(input string nm, input logic [2:0] op, input bit st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] brd, input int ack_after);
      bit acked = 0;
      @(negedge clk);
      req_valid = 1; memwrite = st; memtoreg = !st; mem_op = op; addr = a; wdata = wd;
      bus_ack = 0; bus_rdata = brd;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s accept stall got %0b want 1", nm, stall); end
      checks++; if ({adel, ades, bus_req} !== 3'b000) begin errors++; $display("FAIL %s accept adel/ades/bus_req got %b want 000", nm, {adel, ades, bus_req}); end
      @(negedge clk);
      req_valid = 0; memwrite = 0; memtoreg = 0;
      for (int k = 0; k < TO; k++) begin
         bus_ack = (k == ack_after);
         #1;
         checks++; if (bus_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL %s req%0d bus_req/stall got %b%b want 11", nm, k, bus_req, stall); end
         checks++; if (bus_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s req%0d bus_addr got %h want %h", nm, k, bus_addr, {a[31:2], 2'b00}); end
         checks++; if (bus_we !== st || bus_be !== (st ? exp_be(op, a) : 4'hF)) begin errors++; $display("FAIL %s req%0d we/be got %b/%b want %b/%b", nm, k, bus_we, bus_be, st, st ? exp_be(op, a) : 4'hF); end
         if (st) begin
            checks++; if (bus_wdata !== exp_wd(op, wd)) begin errors++; $display("FAIL %s req%0d bus_wdata got %h want %h", nm, k, bus_wdata, exp_wd(op, wd)); end
         end
         checks++; if (rdata_valid !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL %s req%0d valid/err got %b%b want 00", nm, k, rdata_valid, bus_err); end
         if (k == ack_after) acked = 1;
         @(negedge clk);
         if (acked) break;
      end
      // DONE: re-present the same instruction; it must not be reissued.
      bus_ack = 0; req_valid = 1; memwrite = st; memtoreg = !st;
      if (!acked) exp_rd = 32'h0;
      else if (!st) exp_rd = exp_load(op, a, brd);
      #1;
      checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL %s done stall/bus_req got %b%b want 00", nm, stall, bus_req); end
      checks++; if (rdata_valid !== (acked && !st)) begin errors++; $display("FAIL %s done rdata_valid got %b want %b", nm, rdata_valid, acked && !st); end
      checks++; if (bus_err !== !acked) begin errors++; $display("FAIL %s done bus_err got %b want %b", nm, bus_err, !acked); end
      checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL %s done rdata got %h want %h", nm, rdata, exp_rd); end
      @(negedge clk);
      req_valid = 0; memwrite = 0; memtoreg = 0;
      #1;
      checks++; if ({stall, bus_req, rdata_valid, bus_err} !== 4'b0000) begin errors++; $display("FAIL %s idle stall/req/valid/err got %b want 0000", nm, {stall, bus_req, rdata_valid, bus_err}); end
      checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL %s idle rdata hold got %h want %h", nm, rdata, exp_rd); end
   endtask

   task automatic run_mis(input string nm, input logic [2:0] op, input bit st, input logic [31:0] a);
      @(negedge clk);
      req_valid = 1; memwrite = st; memtoreg = !st; mem_op = op; addr = a; bus_ack = 0;
      #1;
      checks++; if (adel !== !st || ades !== st) begin errors++; $display("FAIL %s adel/ades got %b%b want %b%b", nm, adel, ades, !st, st); end
      checks++; if (bad_addr !== a) begin errors++; $display("FAIL %s bad_addr got %h want %h", nm, bad_addr, a); end
      checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL %s stall/bus_req got %b%b want 00", nm, stall, bus_req); end
      @(negedge clk);
      req_valid = 0; memwrite = 0; memtoreg = 0;
      #1;
      checks++; if ({bus_req, stall, adel, ades} !== 4'b0000) begin errors++; $display("FAIL %s after bus_req/stall/adel/ades got %b want 0000", nm, {bus_req, stall, adel, ades}); end
      checks++; if (bad_addr !== a) begin errors++; $display("FAIL %s bad_addr hold got %h want %h", nm, bad_addr, a); end
   endtask

   task automatic test_reset();
      rst = 1; req_valid = 1; memwrite = 0; memtoreg = 1; mem_op = 3'b000; addr = 32'h0000_0101;
      wdata = 32'h0; bus_ack = 0; bus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if ({stall, adel, ades} !== 3'b000) begin errors++; $display("FAIL reset stall/adel/ades got %b want 000", {stall, adel, ades}); end
      checks++; if ({bus_req, bus_we, bus_be, rdata_valid, bus_err} !== 8'h0) begin errors++; $display("FAIL reset bus ctl got %b want 0", {bus_req, bus_we, bus_be, rdata_valid, bus_err}); end
      checks++; if ({bus_addr, bus_wdata, rdata, bad_addr} !== 128'h0) begin errors++; $display("FAIL reset data got %h want 0", {bus_addr, bus_wdata, rdata, bad_addr}); end
      addr = 32'h0000_0100;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset aligned stall got %b want 0", stall); end
      rst = 0; req_valid = 0; memtoreg = 0;
   endtask

   task automatic test_lb_sign();
      run_txn("lb_sign", 3'b110, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
   endtask

   task automatic test_sh_wait();
      run_txn("sh_wait", 3'b001, 1, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 4);
   endtask

   task automatic test_misaligned();
      run_mis("lw_mis", 3'b000, 0, 32'h0000_3001);
      run_mis("sh_mis", 3'b001, 1, 32'h0000_3003);
   endtask

   task automatic test_timeout();
      run_txn("lhu_to", 3'b101, 0, 32'h0000_4002, 32'h0, 32'hDEAD_BEEF, TO);
   endtask

   task automatic test_reset_mid_req();
      @(negedge clk);
      req_valid = 1; memwrite = 0; memtoreg = 1; mem_op = 3'b000; addr = 32'h0000_6000; bus_ack = 0;
      @(negedge clk);
      req_valid = 0; memtoreg = 0;
      @(negedge clk);
      rst = 1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid stall under rst got %b want 0", stall); end
      @(negedge clk);
      rst = 0; bus_ack = 1; bus_rdata = 32'h1234_5678;
      #1;
      checks++; if ({bus_req, bus_we, bus_be, rdata_valid, bus_err, stall} !== 9'h0) begin errors++; $display("FAIL rst_mid ctl got %b want 0", {bus_req, bus_we, bus_be, rdata_valid, bus_err, stall}); end
      checks++; if ({bus_addr, bus_wdata, rdata, bad_addr} !== 128'h0) begin errors++; $display("FAIL rst_mid data got %h want 0", {bus_addr, bus_wdata, rdata, bad_addr}); end
      exp_rd = 32'h0;
      @(negedge clk);
      bus_ack = 0;
      #1;
      checks++; if ({rdata_valid, bus_req, stall, bus_err} !== 4'b0000) begin errors++; $display("FAIL rst_mid late ack got %b want 0000", {rdata_valid, bus_req, stall, bus_err}); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid rdata got %h want 0", rdata); end
      run_txn("lbu_after_rst", 3'b111, 0, 32'h0000_5001, 32'h0, 32'h0000_9A00, 0);
   endtask

   task automatic test_random();
      logic [2:0] ld_ops [6] = '{3'b000, 3'b110, 3'b111, 3'b100, 3'b101, 3'b011};
      logic [2:0] st_ops [3] = '{3'b000, 3'b010, 3'b001};
      for (int n = 0; n < 40; n++) begin
         bit st = 1'($urandom % 2);
         logic [2:0] op = st ? st_ops[$urandom % 3] : ld_ops[$urandom % 6];
         logic [31:0] a = $urandom;
         int s = op_size(op);
         if ($urandom % 4 != 0) a = a - (a % s);
         if (a % s != 0) run_mis("rand_mis", op, st, a);
         else run_txn("rand", op, st, a, $urandom, $urandom, int'($urandom_range(0, TO + 1)));
      end
   endtask

   initial begin
      test_reset();
      test_lb_sign();
      test_sh_wait();
      test_misaligned();
      test_timeout();
      test_reset_mid_req();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, the number of cycles in REQ without bus_ack before a bus error is flagged.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  a memory instruction is present in the MEM stage.
REQ-005 memwrite  in  1  store; this SHALL take priority over memtoreg when both are 1.
REQ-006 memtoreg  in  1  load.
REQ-007 mem_op  in  3  000 word, 110 LB, 111 LBU, 100 LH, 101 LHU, 010 SB, 001 SH; any other code SHALL be treated as word.
REQ-008 addr  in  32  byte address; wdata  in  32  store source register value.
REQ-009 stall  out  1  holds the pipeline while an access is in flight.
REQ-010 rdata  out  32  extended load result; rdata_valid  out  1  pulses for one cycle with rdata.
REQ-011 adel, ades  out  1 each  misaligned load or store; bad_addr  out  32  the offending address; bus_err  out  1  timeout pulse.
REQ-012 Bus signals: bus_req out 1, bus_we out 1, bus_addr out 32, bus_be out 4, bus_wdata out 32, bus_ack in 1, bus_rdata in 32.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-014 IDLE: a request is accepted when req_valid and (memwrite or memtoreg) and the address is aligned.
  - On accept: latch addr, mem_op, wdata and direction; stall=1 combinationally in that cycle; next state REQ.
REQ-015 Alignment rules:
  - word requires addr[1:0]=00;
  - LH/LHU/SH require addr[0]=0;
  - byte ops are always aligned.
REQ-016 A misaligned request in IDLE SHALL:
  - pulse adel (load) or ades (store) combinationally for that cycle;
  - set bad_addr=addr;
  - keep stall=0, issue no bus activity, and stay in IDLE.
REQ-017 REQ: bus_req=1, bus_addr={latched addr[31:2],2'b00}, and bus_we/bus_be/bus_wdata SHALL be held stable until bus_ack is sampled.
REQ-018 bus_ack SHALL be honoured in the first REQ cycle (minimum latency) and ignored in IDLE and DONE.
REQ-019 On bus_ack in REQ: capture bus_rdata; next state DONE.
REQ-020 The timeout counter SHALL clear on entering REQ and increment each REQ cycle without ack.
  - When it reaches ACK_TIMEOUT: next state DONE with bus_err=1 in DONE and rdata=0.
  - bus_ack in the same cycle as the limit SHALL win: normal completion, no bus_err.
REQ-021 DONE lasts exactly one cycle with:
  - stall=0;
  - rdata_valid=1 for loads and 0 for stores;
  - next state IDLE.
  - req_valid is ignored in DONE, so the same instruction cannot be reissued.
REQ-022 Store lanes (little-endian):
  - SB: bus_be=0001<<addr[1:0], bus_wdata={4{wdata[7:0]}};
  - SH: bus_be=addr[1]?1100:0011, bus_wdata={2{wdata[15:0]}};
  - SW: bus_be=1111, bus_wdata=wdata.
REQ-023 Loads SHALL drive bus_be=1111 and bus_we=0.
REQ-024 Load extraction uses the byte/half selected by latched addr[1:0]:
  - LB/LH sign-extend to 32 bits;
  - LBU/LHU zero-extend;
  - word passes through unchanged.
REQ-025 Minimum round trip SHALL be 3 cycles (IDLE accept, REQ with ack, DONE), with stall high for the first 2.
REQ-026 Outside DONE, rdata SHALL hold its last value, and rdata_valid and bus_err SHALL be 0.

Reset
REQ-027 On rst at a clock edge, including mid-REQ:
  - state=IDLE, counter=0, latched registers=0;
  - bus_req=0, bus_we=0, bus_be=0000, bus_addr=0, bus_wdata=0;
  - rdata=0, rdata_valid=0, bus_err=0, bad_addr=0.
  - An outstanding transaction is abandoned, and a late bus_ack SHALL be ignored.
REQ-028 While rst=1: stall=0, adel=0, ades=0, and no request is accepted.

Verification
REQ-029 LB addr=0x1003, bus_rdata=0x80FF_1234, ack in first REQ cycle -> bus_be=1111, rdata=0xFFFF_FF80, rdata_valid in cycle 3, stall high 2 cycles.
REQ-030 SH addr=0x2002, wdata=0x0000_ABCD, ack after 4 cycles -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_addr=0x2000 stable until ack, stall high 6 cycles.
REQ-031 LW addr=0x3001 -> adel=1 and bad_addr=0x3001 in the same cycle, bus_req never rises, stall=0.
REQ-032 LHU addr=0x4002, bus_ack never asserted, ACK_TIMEOUT=4 -> bus_err pulse after 4 REQ cycles, rdata=0, return to IDLE.
REQ-033 rst asserted in the 2nd REQ cycle of an LW, bus_ack asserted the following cycle -> all outputs zero, no rdata_valid, next LBU addr=0x5001 with bus_rdata=0x0000_9A00 returns 0x0000_009A.
